// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//
// Hardwired control sequencer for the single-bus CPU. A three-cycle fetch
// (FETCH0..FETCH2) is followed by up to five execute steps (T3..T7). Every
// strobe is decoded combinationally from the current state and the opcode in
// IR[31:27]. The one exception is the conditional PC load in T6 of br, which
// also looks at BranchOut.
//
// Optional feature (compile-time macro SINGLE_STEP_EN):
//   defined   - adds the Step input and the PAUSE state. Each completed
//               instruction parks in PAUSE until Step is seen high.
//   undefined - no Step port, and completed instructions go straight back to
//               FETCH0.
//
// Ports
//   Clock      : rising-edge clock shared with the datapath
//   Clear      : synchronous active-high reset (also clears the datapath)
//   IR         : instruction register contents; the opcode is IR[31:27]
//   BranchOut  : CON flip-flop output, used by br in T6
//   Stop       : halt request, honoured only at an instruction boundary
//   Step       : single-step advance (SINGLE_STEP_EN only)
//   Run        : high while executing, low in HALT
//   *out       : bus source selects
//   *in        : register load enables
//   Gra/Grb/Grc/Rout/BAout/Read/Write/IncPC : register-file selects, memory
//                controls and PC increment
//   ADD..NOT   : one-hot ALU operation selects
// -----------------------------------------------------------------------------
module control_unit #(
    parameter int OPW = 5
) (
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        BranchOut,
    input  logic        Stop,
`ifdef SINGLE_STEP_EN
    input  logic        Step,
`endif
    output logic        Run,
    // bus source selects
    output logic        PCout,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        MDRout,
    output logic        HIout,
    output logic        LOout,
    output logic        Cout,
    output logic        RINout,
    // register load enables
    output logic        PCin,
    output logic        IRin,
    output logic        MARin,
    output logic        MDRin,
    output logic        Yin,
    output logic        Zin,
    output logic        LOin,
    output logic        HIin,
    output logic        Rin,
    output logic        RAin,
    output logic        CONin,
    output logic        OutPortIn,
    // register-file selects, memory controls, PC increment
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rout,
    output logic        BAout,
    output logic        Read,
    output logic        Write,
    output logic        IncPC,
    // one-hot ALU operation selects
    output logic        ADD,
    output logic        SUB,
    output logic        AND,
    output logic        OR,
    output logic        ROR,
    output logic        ROL,
    output logic        SHR,
    output logic        SHRA,
    output logic        SHL,
    output logic        MUL,
    output logic        DIV,
    output logic        NEG,
    output logic        NOT
);

    // ------------------------------------------------------------------
    // Opcode map
    // ------------------------------------------------------------------
    localparam logic [OPW-1:0] OP_LD   = 5'b00000;
    localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPW-1:0] OP_ST   = 5'b00010;
    localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPW-1:0] OP_AND  = 5'b00101;
    localparam logic [OPW-1:0] OP_OR   = 5'b00110;
    localparam logic [OPW-1:0] OP_ROR  = 5'b00111;
    localparam logic [OPW-1:0] OP_ROL  = 5'b01000;
    localparam logic [OPW-1:0] OP_SHR  = 5'b01001;
    localparam logic [OPW-1:0] OP_SHRA = 5'b01010;
    localparam logic [OPW-1:0] OP_SHL  = 5'b01011;
    localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
    localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
    localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
    localparam logic [OPW-1:0] OP_DIV  = 5'b01111;
    localparam logic [OPW-1:0] OP_MUL  = 5'b10000;
    localparam logic [OPW-1:0] OP_NEG  = 5'b10001;
    localparam logic [OPW-1:0] OP_NOT  = 5'b10010;
    localparam logic [OPW-1:0] OP_BR   = 5'b10011;
    localparam logic [OPW-1:0] OP_JAL  = 5'b10100;
    localparam logic [OPW-1:0] OP_JR   = 5'b10101;
    localparam logic [OPW-1:0] OP_IN   = 5'b10110;
    localparam logic [OPW-1:0] OP_OUT  = 5'b10111;
    localparam logic [OPW-1:0] OP_MFHI = 5'b11000;
    localparam logic [OPW-1:0] OP_MFLO = 5'b11001;
    localparam logic [OPW-1:0] OP_HALT = 5'b11011;

    // Bit positions inside the packed ALU select vector
    localparam int A_ADD  = 12;
    localparam int A_SUB  = 11;
    localparam int A_AND  = 10;
    localparam int A_OR   = 9;
    localparam int A_ROR  = 8;
    localparam int A_ROL  = 7;
    localparam int A_SHR  = 6;
    localparam int A_SHRA = 5;
    localparam int A_SHL  = 4;
    localparam int A_MUL  = 3;
    localparam int A_DIV  = 2;
    localparam int A_NEG  = 1;
    localparam int A_NOT  = 0;

    typedef enum logic [3:0] {
        FETCH0,
        FETCH1,
        FETCH2,
        T3,
        T4,
        T5,
        T6,
        T7,
        HALT
`ifdef SINGLE_STEP_EN
        ,
        PAUSE
`endif
    } state_t;

    // Where a completed instruction goes when no Stop is pending
`ifdef SINGLE_STEP_EN
    localparam state_t DONE_STATE = PAUSE;
`else
    localparam state_t DONE_STATE = FETCH0;
`endif

    state_t           state_reg;
    state_t           state_next;
    state_t           done_next;
    logic [OPW-1:0]   opcode;
    logic [12:0]      op_alu_vec;
    logic [12:0]      alu_vec;
    logic             alu_fire;
    logic             alu_add;
    logic             unused_ir;

    assign opcode    = IR[31 -: OPW];
    assign unused_ir = ^IR[31-OPW:0];

    // Stop is sampled only on the last step of an instruction, so an
    // instruction already under way always completes.
    assign done_next = Stop ? HALT : DONE_STATE;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_reg <= FETCH0;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Operation select implied by the opcode. The immediate forms reuse
    // the ALU operation of their register counterpart.
    // ------------------------------------------------------------------
    always_comb begin
        op_alu_vec = '0;
        case (opcode)
            OP_ADD, OP_ADDI: op_alu_vec[A_ADD]  = 1'b1;
            OP_SUB:          op_alu_vec[A_SUB]  = 1'b1;
            OP_AND, OP_ANDI: op_alu_vec[A_AND]  = 1'b1;
            OP_OR,  OP_ORI:  op_alu_vec[A_OR]   = 1'b1;
            OP_ROR:          op_alu_vec[A_ROR]  = 1'b1;
            OP_ROL:          op_alu_vec[A_ROL]  = 1'b1;
            OP_SHR:          op_alu_vec[A_SHR]  = 1'b1;
            OP_SHRA:         op_alu_vec[A_SHRA] = 1'b1;
            OP_SHL:          op_alu_vec[A_SHL]  = 1'b1;
            OP_MUL:          op_alu_vec[A_MUL]  = 1'b1;
            OP_DIV:          op_alu_vec[A_DIV]  = 1'b1;
            OP_NEG:          op_alu_vec[A_NEG]  = 1'b1;
            OP_NOT:          op_alu_vec[A_NOT]  = 1'b1;
            default:         op_alu_vec = '0;
        endcase
    end

    // Address and branch-target arithmetic always adds; every other ALU
    // step uses the opcode's own operation.
    always_comb begin
        alu_vec = '0;
        if (alu_fire) begin
            alu_vec = op_alu_vec;
        end else if (alu_add) begin
            alu_vec[A_ADD] = 1'b1;
        end
    end

    assign ADD  = alu_vec[A_ADD];
    assign SUB  = alu_vec[A_SUB];
    assign AND  = alu_vec[A_AND];
    assign OR   = alu_vec[A_OR];
    assign ROR  = alu_vec[A_ROR];
    assign ROL  = alu_vec[A_ROL];
    assign SHR  = alu_vec[A_SHR];
    assign SHRA = alu_vec[A_SHRA];
    assign SHL  = alu_vec[A_SHL];
    assign MUL  = alu_vec[A_MUL];
    assign DIV  = alu_vec[A_DIV];
    assign NEG  = alu_vec[A_NEG];
    assign NOT  = alu_vec[A_NOT];

    // ------------------------------------------------------------------
    // Next-state and strobe decode. Clear suppresses every strobe in the
    // cycle it is high, which also aborts any instruction in flight.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        Run        = 1'b1;
        alu_fire   = 1'b0;
        alu_add    = 1'b0;
        PCout      = 1'b0;
        Zlowout    = 1'b0;
        Zhighout   = 1'b0;
        MDRout     = 1'b0;
        HIout      = 1'b0;
        LOout      = 1'b0;
        Cout       = 1'b0;
        RINout     = 1'b0;
        PCin       = 1'b0;
        IRin       = 1'b0;
        MARin      = 1'b0;
        MDRin      = 1'b0;
        Yin        = 1'b0;
        Zin        = 1'b0;
        LOin       = 1'b0;
        HIin       = 1'b0;
        Rin        = 1'b0;
        RAin       = 1'b0;
        CONin      = 1'b0;
        OutPortIn  = 1'b0;
        Gra        = 1'b0;
        Grb        = 1'b0;
        Grc        = 1'b0;
        Rout       = 1'b0;
        BAout      = 1'b0;
        Read       = 1'b0;
        Write      = 1'b0;
        IncPC      = 1'b0;

        if (Clear) begin
            state_next = FETCH0;
        end else begin
            case (state_reg)
                // IncPC steers the ALU onto its PC+1 path, so no operation
                // select accompanies Zin here.
                FETCH0: begin
                    PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
                    state_next = FETCH1;
                end
                FETCH1: begin
                    Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
                    state_next = FETCH1 == FETCH1 ? FETCH2 : FETCH2;
                end
                FETCH2: begin
                    MDRout = 1'b1; IRin = 1'b1;
                    state_next = T3;
                end
                T3: begin
                    case (opcode)
                        OP_LD, OP_LDI, OP_ST: begin
                            Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                            state_next = T4;
                        end
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
                        OP_SHR, OP_SHRA, OP_SHL,
                        OP_ADDI, OP_ANDI, OP_ORI: begin
                            Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                            state_next = T4;
                        end
                        OP_NEG, OP_NOT: begin
                            Grb = 1'b1; Rout = 1'b1; alu_fire = 1'b1; Zin = 1'b1;
                            state_next = T4;
                        end
                        OP_MUL, OP_DIV: begin
                            Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
                            state_next = T4;
                        end
                        OP_BR: begin
                            Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
                            state_next = T4;
                        end
                        OP_JR: begin
                            Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
                            state_next = done_next;
                        end
                        // Return address goes to R8 before the jump
                        OP_JAL: begin
                            PCout = 1'b1; RAin = 1'b1;
                            state_next = T4;
                        end
                        OP_IN: begin
                            RINout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                            state_next = done_next;
                        end
                        OP_OUT: begin
                            Gra = 1'b1; Rout = 1'b1; OutPortIn = 1'b1;
                            state_next = done_next;
                        end
                        OP_MFHI: begin
                            HIout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                            state_next = done_next;
                        end
                        OP_MFLO: begin
                            LOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                            state_next = done_next;
                        end
                        OP_HALT: begin
                            state_next = HALT;
                        end
                        // nop and undefined opcodes retire silently
                        default: begin
                            state_next = done_next;
                        end
                    endcase
                end
                T4: begin
                    case (opcode)
                        OP_LD, OP_LDI, OP_ST: begin
                            Cout = 1'b1; alu_add = 1'b1; Zin = 1'b1;
                            state_next = T5;
                        end
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
                        OP_SHR, OP_SHRA, OP_SHL: begin
                            Grc = 1'b1; Rout = 1'b1; alu_fire = 1'b1; Zin = 1'b1;
                            state_next = T5;
                        end
                        OP_ADDI, OP_ANDI, OP_ORI: begin
                            Cout = 1'b1; alu_fire = 1'b1; Zin = 1'b1;
                            state_next = T5;
                        end
                        OP_NEG, OP_NOT: begin
                            Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                            state_next = done_next;
                        end
                        OP_MUL, OP_DIV: begin
                            Grb = 1'b1; Rout = 1'b1; alu_fire = 1'b1; Zin = 1'b1;
                            state_next = T5;
                        end
                        OP_BR: begin
                            PCout = 1'b1; Yin = 1'b1;
                            state_next = T5;
                        end
                        OP_JAL: begin
                            Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
                            state_next = done_next;
                        end
                        default: begin
                            state_next = done_next;
                        end
                    endcase
                end
                T5: begin
                    case (opcode)
                        OP_LDI,
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
                        OP_SHR, OP_SHRA, OP_SHL,
                        OP_ADDI, OP_ANDI, OP_ORI: begin
                            Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                            state_next = done_next;
                        end
                        OP_LD, OP_ST: begin
                            Zlowout = 1'b1; MARin = 1'b1;
                            state_next = T6;
                        end
                        OP_MUL, OP_DIV: begin
                            Zlowout = 1'b1; LOin = 1'b1;
                            state_next = T6;
                        end
                        OP_BR: begin
                            Cout = 1'b1; alu_add = 1'b1; Zin = 1'b1;
                            state_next = T6;
                        end
                        default: begin
                            state_next = done_next;
                        end
                    endcase
                end
                T6: begin
                    case (opcode)
                        OP_LD: begin
                            Read = 1'b1; MDRin = 1'b1;
                            state_next = T7;
                        end
                        OP_ST: begin
                            Gra = 1'b1; Rout = 1'b1; Write = 1'b1;
                            state_next = done_next;
                        end
                        OP_MUL, OP_DIV: begin
                            Zhighout = 1'b1; HIin = 1'b1;
                            state_next = done_next;
                        end
                        // Branch target already sits in Z; commit it only
                        // when the condition evaluated true.
                        OP_BR: begin
                            Zlowout = BranchOut;
                            PCin    = BranchOut;
                            state_next = done_next;
                        end
                        default: begin
                            state_next = done_next;
                        end
                    endcase
                end
                T7: begin
                    if (opcode == OP_LD) begin
                        MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                    state_next = done_next;
                end
                HALT: begin
                    Run        = 1'b0;
                    state_next = HALT;
                end
`ifdef SINGLE_STEP_EN
                PAUSE: begin
                    if (Stop) begin
                        state_next = HALT;
                    end else if (Step) begin
                        state_next = FETCH0;
                    end
                end
`endif
                default: begin
                    state_next = FETCH0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
//
// Scoreboard bench for control_unit. For every instruction the expected
// per-cycle strobe vectors are written out from the opcode table and pushed
// to a queue. They are then popped one per cycle and compared with the
// packed DUT outputs, which are sampled 1 ns after each falling edge.
// -----------------------------------------------------------------------------
module tb_control_unit;

    logic        Clock = 1'b0;
    logic        Clear;
    logic [31:0] IR;
    logic        BranchOut;
    logic        Stop;
`ifdef SINGLE_STEP_EN
    logic        Step;
`endif
    logic Run;
    logic PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Cout, RINout;
    logic PCin, IRin, MARin, MDRin, Yin, Zin, LOin, HIin, Rin, RAin, CONin, OutPortIn;
    logic Gra, Grb, Grc, Rout, BAout, Read, Write, IncPC;
    logic ADD, SUB, AND, OR, ROR, ROL, SHR, SHRA, SHL, MUL, DIV, NEG, NOT;

    always #5 Clock = ~Clock;

    control_unit #(.OPW(5)) dut (
        .Clock(Clock), .Clear(Clear), .IR(IR), .BranchOut(BranchOut), .Stop(Stop),
`ifdef SINGLE_STEP_EN
        .Step(Step),
`endif
        .Run(Run),
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .Cout(Cout), .RINout(RINout),
        .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .Zin(Zin),
        .LOin(LOin), .HIin(HIin), .Rin(Rin), .RAin(RAin), .CONin(CONin),
        .OutPortIn(OutPortIn),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rout(Rout), .BAout(BAout),
        .Read(Read), .Write(Write), .IncPC(IncPC),
        .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .ROR(ROR), .ROL(ROL),
        .SHR(SHR), .SHRA(SHRA), .SHL(SHL), .MUL(MUL), .DIV(DIV), .NEG(NEG), .NOT(NOT)
    );

    typedef logic [41:0] vec_t;

    vec_t obs;
    assign obs = {Run, PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Cout, RINout,
                  PCin, IRin, MARin, MDRin, Yin, Zin, LOin, HIin, Rin, RAin, CONin,
                  OutPortIn, Gra, Grb, Grc, Rout, BAout, Read, Write, IncPC,
                  ADD, SUB, AND, OR, ROR, ROL, SHR, SHRA, SHL, MUL, DIV, NEG, NOT};

    localparam vec_t M_RUN   = vec_t'(1) << 41;
    localparam vec_t M_PCO   = vec_t'(1) << 40;
    localparam vec_t M_ZLO   = vec_t'(1) << 39;
    localparam vec_t M_ZHO   = vec_t'(1) << 38;
    localparam vec_t M_MDRO  = vec_t'(1) << 37;
    localparam vec_t M_HIO   = vec_t'(1) << 36;
    localparam vec_t M_LOO   = vec_t'(1) << 35;
    localparam vec_t M_CO    = vec_t'(1) << 34;
    localparam vec_t M_RINO  = vec_t'(1) << 33;
    localparam vec_t M_PCI   = vec_t'(1) << 32;
    localparam vec_t M_IRI   = vec_t'(1) << 31;
    localparam vec_t M_MARI  = vec_t'(1) << 30;
    localparam vec_t M_MDRI  = vec_t'(1) << 29;
    localparam vec_t M_YI    = vec_t'(1) << 28;
    localparam vec_t M_ZI    = vec_t'(1) << 27;
    localparam vec_t M_LOI   = vec_t'(1) << 26;
    localparam vec_t M_HII   = vec_t'(1) << 25;
    localparam vec_t M_RI    = vec_t'(1) << 24;
    localparam vec_t M_RAI   = vec_t'(1) << 23;
    localparam vec_t M_CONI  = vec_t'(1) << 22;
    localparam vec_t M_OPI   = vec_t'(1) << 21;
    localparam vec_t M_GRA   = vec_t'(1) << 20;
    localparam vec_t M_GRB   = vec_t'(1) << 19;
    localparam vec_t M_GRC   = vec_t'(1) << 18;
    localparam vec_t M_ROUT  = vec_t'(1) << 17;
    localparam vec_t M_BAO   = vec_t'(1) << 16;
    localparam vec_t M_READ  = vec_t'(1) << 15;
    localparam vec_t M_WRITE = vec_t'(1) << 14;
    localparam vec_t M_INCPC = vec_t'(1) << 13;
    localparam vec_t M_ADD   = vec_t'(1) << 12;
    localparam vec_t M_SUB   = vec_t'(1) << 11;
    localparam vec_t M_AND   = vec_t'(1) << 10;
    localparam vec_t M_OR    = vec_t'(1) << 9;
    localparam vec_t M_ROR   = vec_t'(1) << 8;
    localparam vec_t M_ROL   = vec_t'(1) << 7;
    localparam vec_t M_SHR   = vec_t'(1) << 6;
    localparam vec_t M_SHRA  = vec_t'(1) << 5;
    localparam vec_t M_SHL   = vec_t'(1) << 4;
    localparam vec_t M_MUL   = vec_t'(1) << 3;
    localparam vec_t M_DIV   = vec_t'(1) << 2;
    localparam vec_t M_NEG   = vec_t'(1) << 1;
    localparam vec_t M_NOT   = vec_t'(1) << 0;

    vec_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   pause_cycles = 2;

    task automatic check(input string tag, input vec_t got, input vec_t want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // Normal-running cycle: listed strobes plus Run
    task automatic push_run(input vec_t m);
        exp_q.push_back(m | M_RUN);
    endtask

    function automatic vec_t alu_mask(input logic [4:0] opc);
        case (opc)
            5'd3, 5'd12: return M_ADD;
            5'd4:        return M_SUB;
            5'd5, 5'd13: return M_AND;
            5'd6, 5'd14: return M_OR;
            5'd7:        return M_ROR;
            5'd8:        return M_ROL;
            5'd9:        return M_SHR;
            5'd10:       return M_SHRA;
            5'd11:       return M_SHL;
            5'd15:       return M_DIV;
            5'd16:       return M_MUL;
            5'd17:       return M_NEG;
            5'd18:       return M_NOT;
            default:     return '0;
        endcase
    endfunction

    // Runs one instruction starting from FETCH0.
    //   stop    : hold Stop high for the whole instruction (must not truncate)
    //   clr_idx : cycle index (0 = FETCH0) at which Clear is pulsed to abort;
    //             -1 for none
    //   halt_n  : cycles to observe HALT when the instruction ends there
    task automatic run_instr(input string tag, input logic [31:0] ir, input logic br,
                             input logic stop, input int clr_idx, input int halt_n);
        logic [4:0] opc;
        vec_t       op_m;
        int         n;
        int         step_idx;
        int         clr_at;
        bit         halting;
        opc      = ir[31:27];
        op_m     = alu_mask(opc);
        IR       = ir;
        BranchOut = br;
        Stop     = stop;
        step_idx = -1;
        clr_at   = clr_idx;
        exp_q.delete();

        push_run(M_PCO | M_MARI | M_INCPC | M_ZI);
        push_run(M_ZLO | M_PCI | M_READ | M_MDRI);
        push_run(M_MDRO | M_IRI);
        case (opc)
            5'd0, 5'd1, 5'd2: begin
                push_run(M_GRB | M_BAO | M_YI);
                push_run(M_CO | M_ADD | M_ZI);
                if (opc == 5'd1) begin
                    push_run(M_ZLO | M_GRA | M_RI);
                end else begin
                    push_run(M_ZLO | M_MARI);
                    if (opc == 5'd0) begin
                        push_run(M_READ | M_MDRI);
                        push_run(M_MDRO | M_GRA | M_RI);
                    end else begin
                        push_run(M_GRA | M_ROUT | M_WRITE);
                    end
                end
            end
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11: begin
                push_run(M_GRB | M_ROUT | M_YI);
                push_run(M_GRC | M_ROUT | op_m | M_ZI);
                push_run(M_ZLO | M_GRA | M_RI);
            end
            5'd12, 5'd13, 5'd14: begin
                push_run(M_GRB | M_ROUT | M_YI);
                push_run(M_CO | op_m | M_ZI);
                push_run(M_ZLO | M_GRA | M_RI);
            end
            5'd15, 5'd16: begin
                push_run(M_GRA | M_ROUT | M_YI);
                push_run(M_GRB | M_ROUT | op_m | M_ZI);
                push_run(M_ZLO | M_LOI);
                push_run(M_ZHO | M_HII);
            end
            5'd17, 5'd18: begin
                push_run(M_GRB | M_ROUT | op_m | M_ZI);
                push_run(M_ZLO | M_GRA | M_RI);
            end
            5'd19: begin
                push_run(M_GRA | M_ROUT | M_CONI);
                push_run(M_PCO | M_YI);
                push_run(M_CO | M_ADD | M_ZI);
                push_run(br ? (M_ZLO | M_PCI) : '0);
            end
            5'd20: begin
                push_run(M_PCO | M_RAI);
                push_run(M_GRA | M_ROUT | M_PCI);
            end
            5'd21: push_run(M_GRA | M_ROUT | M_PCI);
            5'd22: push_run(M_RINO | M_GRA | M_RI);
            5'd23: push_run(M_GRA | M_ROUT | M_OPI);
            5'd24: push_run(M_HIO | M_GRA | M_RI);
            5'd25: push_run(M_LOO | M_GRA | M_RI);
            default: push_run('0);
        endcase

        halting = stop || (opc == 5'd27);
        if (clr_at >= 0) begin
            // Aborted: only the Clear cycle follows the cycles already run
            while (exp_q.size() > clr_at) void'(exp_q.pop_back());
            exp_q.push_back(M_RUN);
        end else if (halting) begin
            for (int i = 0; i < halt_n; i++) exp_q.push_back('0);
            clr_at = exp_q.size();
            exp_q.push_back(M_RUN);
        end else begin
`ifdef SINGLE_STEP_EN
            for (int i = 0; i < pause_cycles; i++) exp_q.push_back(M_RUN);
            step_idx = exp_q.size();
            exp_q.push_back(M_RUN);
`endif
        end

        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            Clear = (i == clr_at);
            if (i == clr_at) Stop = 1'b0;
`ifdef SINGLE_STEP_EN
            Step = (i == step_idx);
`endif
            #1;
            check($sformatf("%s.c%0d", tag, i), obs, exp_q.pop_front());
            @(negedge Clock);
        end
        Clear = 1'b0;
        Stop  = 1'b0;
`ifdef SINGLE_STEP_EN
        Step  = 1'b0;
`endif
        $display("txn %-8s ir=%h br=%0d stop=%0d clr=%0d cycles=%0d", tag, ir, br, stop, clr_idx, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Clear     = 1'b1;
        IR        = '0;
        BranchOut = 1'b0;
        Stop      = 1'b0;
`ifdef SINGLE_STEP_EN
        Step      = 1'b0;
`endif
        @(negedge Clock);
        @(negedge Clock);
        #1;
        check("reset", obs, M_RUN);
        @(negedge Clock);
        Clear = 1'b0;

        // Directed add R2,R3,R4
        run_instr("add_dir", 32'h191A0000, 1'b0, 1'b0, -1, 0);

        // Every opcode except halt, with random operand fields
        for (int k = 0; k < 32; k++) begin
            logic [4:0]  kop;
            logic [26:0] fld;
            kop = 5'(k);
            fld = 27'($urandom);
            if (k != 27) begin
                run_instr($sformatf("op%0d", k), {kop, fld}, 1'($urandom), 1'b0, -1, 0);
            end
        end

        // Branch taken and not taken
        run_instr("br_t",  {5'd19, 27'h0123456}, 1'b1, 1'b0, -1, 0);
        run_instr("br_nt", {5'd19, 27'h0123456}, 1'b0, 1'b0, -1, 0);
        run_instr("mul",   {5'd16, 27'h0}, 1'b0, 1'b0, -1, 0);

        // Clear in T4 of mul aborts it; next instruction starts cleanly
        run_instr("mul_clr", {5'd16, 27'h0}, 1'b0, 1'b0, 4, 0);
        // Clear in T6 of ld
        run_instr("ld_clr",  {5'd0, 27'h0}, 1'b0, 1'b0, 6, 0);

        // Stop held throughout add: instruction completes, then HALT
        run_instr("add_stop", 32'h191A0000, 1'b0, 1'b1, -1, 5);
        // Stop on a one-step instruction
        run_instr("jr_stop", {5'd21, 27'h0}, 1'b0, 1'b1, -1, 3);

        // halt instruction: 100 idle cycles, then one Clear cycle
        run_instr("halt", {5'd27, 27'h0}, 1'b0, 1'b0, -1, 100);
        run_instr("add_post", 32'h191A0000, 1'b0, 1'b0, -1, 0);

`ifdef SINGLE_STEP_EN
        pause_cycles = 20;
        run_instr("add_pause", 32'h191A0000, 1'b0, 1'b0, -1, 0);
        pause_cycles = 2;
`endif
        run_instr("nop_end", {5'd26, 27'h0}, 1'b0, 1'b0, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter: OPW, 5, opcode width, taken from IR[31:27].
REQ-002 Clock  in  1  rising-edge clock shared with the datapath.
REQ-003 Clear  in  1  synchronous, active-high reset; the datapath registers use the same Clear.
REQ-004 IR  in  32  instruction register contents from the datapath.
REQ-005 BranchOut  in  1  CON flip-flop output.
REQ-006 Stop  in  1  halt request, taken at the instruction boundary.
REQ-007 Step  in  1  single-step advance; exists only under SINGLE_STEP_EN.
REQ-008 Run  out  1  high while executing; low in HALT.
REQ-009 PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Cout, RINout  out  1 each  bus source selects.
REQ-010 PCin, IRin, MARin, MDRin, Yin, Zin, LOin, HIin, Rin, RAin, CONin, OutPortIn  out  1 each  register load enables.
REQ-011 Gra, Grb, Grc, Rout, BAout, Read, Write, IncPC  out  1 each  register-file selects, memory controls and PC increment.
REQ-012 ADD, SUB, AND, OR, ROR, ROL, SHR, SHRA, SHL, MUL, DIV, NEG, NOT  out  1 each  one-hot ALU operation selects.

Function
REQ-013 The FSM states shall be FETCH0, FETCH1, FETCH2, T3..T7 and HALT, plus PAUSE when SINGLE_STEP_EN is defined.
REQ-014 The state register shall update only on the rising edge of Clock.
REQ-015 All outputs shall be decoded combinationally from the state and IR[31:27]; the only exception is T6 of br, which also depends on BranchOut.
REQ-016 Any strobe not listed for the current state shall be 0.
REQ-017 Fetch sequence:
- FETCH0: PCout, MARin, IncPC, Zin.
- FETCH1: Zlowout, PCin, Read, MDRin.
- FETCH2: MDRout, IRin.
REQ-018 Opcode map: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011, addi 01100, andi 01101, ori 01110, div 01111, mul 10000, neg 10001, not 10010, br 10011, jal 10100, jr 10101, in 10110, out 10111, mfhi 11000, mflo 11001, nop 11010, halt 11011.
REQ-019 Register-type ALU ops (add..shl):
- T3: Grb, Rout, Yin.
- T4: Grc, Rout, op, Zin.
- T5: Zlowout, Gra, Rin.
REQ-020 addi/andi/ori:
- T3: Grb, Rout, Yin.
- T4: Cout, op, Zin (op is ADD, AND or OR respectively).
- T5: Zlowout, Gra, Rin.
REQ-021 neg/not:
- T3: Grb, Rout, op, Zin.
- T4: Zlowout, Gra, Rin.
REQ-022 mul/div:
- T3: Gra, Rout, Yin.
- T4: Grb, Rout, op, Zin.
- T5: Zlowout, LOin.
- T6: Zhighout, HIin.
REQ-023 ld/ldi/st shall share T3 (Grb, BAout, Yin) and T4 (Cout, ADD, Zin).
- ldi T5: Zlowout, Gra, Rin.
- ld T5: Zlowout, MARin. ld T6: Read, MDRin. ld T7: MDRout, Gra, Rin.
- st T5: Zlowout, MARin. st T6: Gra, Rout, Write.
REQ-024 br:
- T3: Gra, Rout, CONin.
- T4: PCout, Yin.
- T5: Cout, ADD, Zin.
- T6: Zlowout and PCin only if BranchOut=1; otherwise no strobes.
REQ-025 jr T3: Gra, Rout, PCin.
REQ-026 jal T3: PCout, RAin (loads R8). jal T4: Gra, Rout, PCin.
REQ-027 Single-step register/port moves, all in T3:
- in: RINout, Gra, Rin.
- out: Gra, Rout, OutPortIn.
- mfhi: HIout, Gra, Rin.
- mflo: LOout, Gra, Rin.
REQ-028 nop and any undefined opcode shall return to FETCH0 from T3 with no strobes.
REQ-029 halt shall enter HALT from T3; HALT holds all strobes at 0 with Run=0 until Clear.
REQ-030 After the last step of an instruction, the next state shall be FETCH0, or HALT if Stop=1 in that cycle.
REQ-031 Stop asserted mid-instruction shall not truncate the instruction.
REQ-032 Exactly one ALU op select shall be high in any cycle where Zin=1.

Reset
REQ-033 Clear=1 at a rising edge shall force FETCH0 on the next cycle, from any state including HALT and PAUSE.
REQ-034 While Clear=1, all strobes shall be 0 and Run=1.
REQ-035 Clear mid-instruction shall abort the instruction with no further strobes for it.

Configuration
REQ-036 Macro SINGLE_STEP_EN:
- Defined: the Step port exists, and each completed instruction goes to PAUSE instead of FETCH0. PAUSE holds all strobes at 0 with Run=1 and advances to FETCH0 on the cycle Step=1. Stop is still honoured from PAUSE.
- Undefined: no Step port and no PAUSE state.

Verification
REQ-037 Release Clear -> FETCH0/1/2 strobes exactly as REQ-017 in cycles 0, 1 and 2.
REQ-038 IR=0x191A0000 (add R2,R3,R4) -> T3 Grb+Rout+Yin, T4 Grc+Rout+ADD+Zin, T5 Zlowout+Gra+Rin; FETCH0 at cycle 6.
REQ-039 IR opcode 10011 with BranchOut=1 -> T6 Zlowout+PCin; with BranchOut=0 -> T6 all strobes 0; FETCH0 follows in both cases.
REQ-040 IR opcode 10000 (mul) -> T5 Zlowout+LOin, T6 Zhighout+HIin; FETCH0 at cycle 7.
REQ-041 IR opcode 11011 -> Run=0 and all strobes 0 for 100 cycles; one Clear cycle -> Run=1 and FETCH0 strobes.
REQ-042 SINGLE_STEP_EN defined, add executed -> PAUSE with strobes 0 for 20 cycles; Step pulsed for 1 cycle -> FETCH0 on the next cycle.
